// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC sample scheduler: APB register word
// indices, CTRL/STATUS bit positions, FSM states and the channel search
// helper used by the scan sequencer.
package adc_sched_pkg;

   // Register word index, decoded from paddr[4:2]
   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_CHMASK = 3'd1;
   localparam logic [2:0] REG_PERIOD = 3'd2;
   localparam logic [2:0] REG_STATUS = 3'd3;
   localparam logic [2:0] REG_DATA   = 3'd4;

   // CTRL bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int CTRL_IRQ_EN  = 2;

   // STATUS bit positions (LEVEL is a 4-bit field starting at STAT_LEVEL)
   localparam int STAT_BUSY  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_FULL  = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_LEVEL = 8;

   // Scan index width: one more than needed for 16 channels so that
   // "past the last channel" is representable without wrapping to 0.
   localparam int IDX_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SCAN,
      ST_REQ
   } state_t;

   // Lowest set bit of mask at or above start; returns 16 when none is left.
   function automatic logic [IDX_W-1:0] next_chan(input logic [15:0]      mask,
                                                   input logic [IDX_W-1:0] start);
      logic [IDX_W-1:0] found;
      found = IDX_W'(16);
      for (int i = 15; i >= 0; i--) begin
         if (mask[i] && (IDX_W'(i) >= start)) begin
            found = IDX_W'(i);
         end
      end
      return found;
   endfunction

endpackage

// File: rtl/adc_sched_fifo.sv
// Synchronous result FIFO for the ADC scheduler. A push into a full FIFO
// is accepted only when a pop happens in the same cycle; a pop from an
// empty FIFO is ignored. DEPTH must be a power of two, at least 2.
module adc_sched_fifo
   import adc_sched_pkg::*;
#(
   parameter int WIDTH = 15,
   parameter int DEPTH = 8
) (
   input  logic                     fclk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == (PTR_W+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign level    = count_q;
   assign pop_data = mem[rd_ptr_q];
   assign push_ok  = push && (!full || pop);
   assign pop_ok   = pop && !empty;

   // Pointer and occupancy next-state
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge fclk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: state uses non-blocking assignments so all registers update together at the edge.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write
   always_ff @(posedge fclk) begin
      // NOTE: the array has no reset; stale entries are unreachable because count_q gates every read.
      if (push_ok) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/adc_sample_scheduler.sv
// APB-controlled ADC sample scheduler: a period counter triggers round-robin
// scans over the enabled channels, each channel gets one req/ack conversion
// and the {channel, sample} result is queued for the CPU to read out.
// Build option: define ADC_SCHED_IRQ_EN to add the CTRL.IRQ_EN bit and the
// registered level interrupt; without it irq is tied low.
module adc_sample_scheduler
   import adc_sched_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int NCH        = 8,
   parameter int CH_W       = 3,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 8,
   parameter int PERIOD_W   = 24
) (
   input  logic              fclk,
   input  logic              resetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              adc_req,
   output logic [CH_W-1:0]   adc_chan,
   input  logic              adc_ack,
   input  logic [DATA_W-1:0] adc_data,
   output logic              irq
);

   localparam int FIFO_W = CH_W + DATA_W;
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

   // APB decode
   logic        apb_setup, apb_wr, apb_rd_acc;
   logic [2:0]  reg_idx;
   logic        unused_apb;

   // Software-visible registers
   logic                en_q, en_d;
   logic                oneshot_q, oneshot_d;
   logic [NCH-1:0]      chmask_q, chmask_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                ovf_q, ovf_d;
   logic [31:0]         prdata_q, prdata_d, rd_word;

   // Period counter and pending tick
   logic [PERIOD_W-1:0] cnt_q, cnt_d, period_m1;
   logic                tick;
   logic                pending_q, pending_d;

   // Scan sequencer
   state_t              state_q, state_d;
   logic [NCH-1:0]      scan_mask_q, scan_mask_d;
   logic [IDX_W-1:0]    scan_idx_q, scan_idx_d, nxt_idx;
   logic [CH_W-1:0]     chan_q, chan_d;
   logic                scan_start, oneshot_done, busy;

   // Result FIFO
   logic                push, pop, ovf_set;
   logic                pop_armed_q, pop_armed_d;
   logic [FIFO_W-1:0]   fifo_head;
   logic                fifo_full, fifo_empty;
   logic [LVL_W-1:0]    fifo_level;

`ifdef ADC_SCHED_IRQ_EN
   logic irq_en_q, irq_en_d, irq_q;
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign apb_setup  = psel && !penable;
   assign apb_wr     = psel && penable && pwrite;
   assign apb_rd_acc = psel && penable && !pwrite;
   assign reg_idx    = paddr[4:2];
   assign unused_apb = ^{paddr, pwdata};

   assign pready   = 1'b1;
   assign pslverr  = 1'b0;
   assign prdata   = prdata_q;
   assign adc_req  = (state_q == ST_REQ);
   assign adc_chan = chan_q;
   assign busy     = (state_q == ST_SCAN) || (state_q == ST_REQ);

   // The ack cycle pushes; a DATA pop only happens if the setup phase saw data to return
   assign push    = (state_q == ST_REQ) && adc_ack;
   assign pop     = pop_armed_q && apb_rd_acc;
   assign ovf_set = push && fifo_full && !pop;

   // Period tick; >= keeps the counter from running the full 2^PERIOD_W range if PERIOD shrinks under it
   assign period_m1 = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
   assign tick      = en_q && (cnt_q >= period_m1);
   assign nxt_idx   = next_chan(16'(scan_mask_q), scan_idx_q);

   adc_sched_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .fclk      (fclk),
      .resetn    (resetn),
      .push      (push),
      .push_data ({chan_q, adc_data}),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Read mux for the register addressed in the setup phase
   always_comb begin
      rd_word = '0;
      case (reg_idx)
         REG_CTRL: begin
            rd_word[CTRL_EN]      = en_q;
            rd_word[CTRL_ONESHOT] = oneshot_q;
`ifdef ADC_SCHED_IRQ_EN
            rd_word[CTRL_IRQ_EN]  = irq_en_q;
`endif
         end
         REG_CHMASK: rd_word[NCH-1:0]      = chmask_q;
         REG_PERIOD: rd_word[PERIOD_W-1:0] = period_q;
         REG_STATUS: begin
            rd_word[STAT_BUSY]        = busy;
            rd_word[STAT_EMPTY]       = fifo_empty;
            rd_word[STAT_FULL]        = fifo_full;
            rd_word[STAT_OVF]         = ovf_q;
            rd_word[STAT_LEVEL +: 4]  = 4'(fifo_level);
         end
         REG_DATA: begin
            if (!fifo_empty) begin
               rd_word = {12'h000, 4'(fifo_head[FIFO_W-1 -: CH_W]), 16'(fifo_head[DATA_W-1:0])};
            end
         end
         default: rd_word = '0;
      endcase
   end

   // Register-file next state: software writes override the ONESHOT hardware clear
   always_comb begin
      en_d        = en_q;
      oneshot_d   = oneshot_q;
      chmask_d    = chmask_q;
      period_d    = period_q;
      ovf_d       = ovf_q;
      prdata_d    = apb_setup ? rd_word : prdata_q;
      pop_armed_d = apb_setup && (reg_idx == REG_DATA) && !fifo_empty;
`ifdef ADC_SCHED_IRQ_EN
      irq_en_d    = irq_en_q;
`endif
      if (oneshot_done) en_d = 1'b0;
      if (apb_wr) begin
         case (reg_idx)
            REG_CTRL: begin
               en_d      = pwdata[CTRL_EN];
               oneshot_d = pwdata[CTRL_ONESHOT];
`ifdef ADC_SCHED_IRQ_EN
               irq_en_d  = pwdata[CTRL_IRQ_EN];
`endif
            end
            REG_CHMASK: chmask_d = pwdata[NCH-1:0];
            REG_PERIOD: period_d = pwdata[PERIOD_W-1:0];
            REG_STATUS: if (pwdata[STAT_OVF]) ovf_d = 1'b0;
            default: ;
         endcase
      end
      // A drop in the same cycle as the W1C keeps the flag set
      if (ovf_set) ovf_d = 1'b1;
   end

   // Period counter and the 1-deep pending tick latched while a scan is running
   always_comb begin
      cnt_d     = (!en_q || tick) ? '0 : cnt_q + PERIOD_W'(1);
      pending_d = pending_q;
      if (!en_q || scan_start) pending_d = 1'b0;
      else if (tick && busy)   pending_d = 1'b1;
   end

   // Scan sequencer next state
   always_comb begin
      state_d      = state_q;
      scan_mask_d  = scan_mask_q;
      scan_idx_d   = scan_idx_q;
      chan_d       = chan_q;
      scan_start   = 1'b0;
      oneshot_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en_q) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!en_q) begin
               state_d = ST_IDLE;
            end else if (tick || pending_q) begin
               state_d     = ST_SCAN;
               scan_start  = 1'b1;
               scan_mask_d = chmask_q;
               scan_idx_d  = '0;
            end
         end
         ST_SCAN: begin
            if (!en_q) begin
               state_d = ST_IDLE;
            end else if (nxt_idx < IDX_W'(NCH)) begin
               chan_d  = nxt_idx[CH_W-1:0];
               state_d = ST_REQ;
            end else if (oneshot_q) begin
               oneshot_done = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_REQ: begin
            if (adc_ack) begin
               scan_idx_d = IDX_W'(chan_q) + IDX_W'(1);
               state_d    = en_q ? ST_SCAN : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All scheduler state registers
   always_ff @(posedge fclk or negedge resetn) begin
      if (!resetn) begin
         en_q        <= 1'b0;
         oneshot_q   <= 1'b0;
         chmask_q    <= '0;
         period_q    <= '0;
         ovf_q       <= 1'b0;
         prdata_q    <= '0;
         pop_armed_q <= 1'b0;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         state_q     <= ST_IDLE;
         scan_mask_q <= '0;
         scan_idx_q  <= '0;
         chan_q      <= '0;
`ifdef ADC_SCHED_IRQ_EN
         irq_en_q    <= 1'b0;
         irq_q       <= 1'b0;
`endif
      end else begin
         en_q        <= en_d;
         oneshot_q   <= oneshot_d;
         chmask_q    <= chmask_d;
         period_q    <= period_d;
         ovf_q       <= ovf_d;
         prdata_q    <= prdata_d;
         pop_armed_q <= pop_armed_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         state_q     <= state_d;
         scan_mask_q <= scan_mask_d;
         scan_idx_q  <= scan_idx_d;
         chan_q      <= chan_d;
`ifdef ADC_SCHED_IRQ_EN
         irq_en_q    <= irq_en_d;
         irq_q       <= irq_en_q && (!fifo_empty || ovf_q);
`endif
      end
   end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Self-checking bench for adc_sample_scheduler: a register table exercised in
// a loop, then directed multi-cycle sequences (periodic scan, one-shot,
// overflow, EN cleared mid-request, empty mask, reset mid-request).
module tb_adc_sample_scheduler;

`ifdef ADC_SCHED_IRQ_EN
   localparam bit IRQ_BUILT = 1'b1;
`else
   localparam bit IRQ_BUILT = 1'b0;
`endif

   localparam int ACK_DLY = 4;

   localparam logic [15:0] A_CTRL   = 16'h0000;
   localparam logic [15:0] A_CHMASK = 16'h0004;
   localparam logic [15:0] A_PERIOD = 16'h0008;
   localparam logic [15:0] A_STATUS = 16'h000C;
   localparam logic [15:0] A_DATA   = 16'h0010;

   logic        fclk = 1'b0;
   logic        resetn;
   logic        psel, penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        adc_req;
   logic [2:0]  adc_chan;
   logic        adc_ack;
   logic [11:0] adc_data;
   logic        irq;

   int total = 0;
   int bad   = 0;

   adc_sample_scheduler dut (
      .fclk     (fclk),
      .resetn   (resetn),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr),
      .adc_req  (adc_req),
      .adc_chan (adc_chan),
      .adc_ack  (adc_ack),
      .adc_data (adc_data),
      .irq      (irq)
   );

   initial forever #5 fclk = ~fclk;

   int cyc = 0;
   initial forever begin
      @(posedge fclk);
      cyc++;
   end

   // ADC model: acks ACK_DLY sampled cycles into a request (auto mode) or on demand (manual mode)
   typedef struct {
      logic [3:0]  chan;
      logic [11:0] data;
      int          rise;
   } ack_t;

   ack_t ack_log[$];
   bit   adc_auto  = 1'b1;
   int   man_go    = 0;
   int   man_done  = 0;
   int   req_rises = 0;

   initial begin
      int   wait_cnt;
      int   seq;
      int   last_rise;
      bit   prev_req;
      ack_t e;
      wait_cnt  = 0;
      seq       = 1;
      last_rise = 0;
      prev_req  = 1'b0;
      adc_ack   = 1'b0;
      adc_data  = '0;
      forever begin
         @(negedge fclk);
         adc_ack = 1'b0;
         if (adc_req && !prev_req) begin
            req_rises++;
            last_rise = cyc;
         end
         prev_req = adc_req;
         if (adc_req) begin
            wait_cnt++;
            if ((adc_auto && wait_cnt >= ACK_DLY) || (man_go != man_done)) begin
               if (man_go != man_done) man_done++;
               adc_ack  = 1'b1;
               adc_data = 12'(seq * 291 + 7);
               seq++;
               e.chan = 4'(adc_chan);
               e.data = adc_data;
               e.rise = last_rise;
               ack_log.push_back(e);
               wait_cnt = 0;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", name, got, want);
      end
   endtask

   task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
      @(negedge fclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge fclk);
      penable = 1'b1;
      @(negedge fclk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
      @(negedge fclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(negedge fclk);
      penable = 1'b1;
      d = prdata;
      @(negedge fclk);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic read_check(input logic [15:0] a, input logic [31:0] want, input string name);
      logic [31:0] d;
      apb_read(a, d);
      check(name, d, want);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge fclk);
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (ack_log.size() < n && k < budget) begin
         @(negedge fclk);
         k++;
      end
      check(name, ack_log.size(), n);
   endtask

   task automatic wait_req(input int budget, input string name);
      int k;
      k = 0;
      while (!adc_req && k < budget) begin
         @(negedge fclk);
         k++;
      end
      check(name, 32'(adc_req), 32'd1);
   endtask

   function automatic logic [31:0] exp_word(input ack_t a);
      return {12'h000, a.chan, 4'h0, a.data};
   endfunction

   // Register table: optional write, then a read with its expected value
   typedef struct {
      bit          do_wr;
      logic [15:0] waddr;
      logic [31:0] wdata;
      logic [15:0] raddr;
      logic [31:0] want;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input bit w, input logic [15:0] wa, input logic [31:0] wd,
                          input logic [15:0] ra, input logic [31:0] want, input string name);
      vec_t v;
      v.do_wr = w; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.want = want; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] ctrl_w6;
      int          rises0;
      ctrl_w6 = IRQ_BUILT ? 32'h6 : 32'h2;

      add_vec(0, 16'h0,   32'h0,        A_CTRL,   32'h0,        "ctrl_rst");
      add_vec(0, 16'h0,   32'h0,        A_CHMASK, 32'h0,        "chmask_rst");
      add_vec(0, 16'h0,   32'h0,        A_PERIOD, 32'h0,        "period_rst");
      add_vec(0, 16'h0,   32'h0,        A_STATUS, 32'h2,        "status_rst");
      add_vec(0, 16'h0,   32'h0,        A_DATA,   32'h0,        "data_empty");
      add_vec(0, 16'h0,   32'h0,        A_STATUS, 32'h2,        "level_after_empty_read");
      add_vec(1, A_CHMASK, 32'h1A5,     A_CHMASK, 32'hA5,       "chmask_width");
      add_vec(1, A_PERIOD, 32'hFFFFFFFF, A_PERIOD, 32'h00FFFFFF, "period_width");
      add_vec(1, A_CTRL,   32'h6,       A_CTRL,   ctrl_w6,      "ctrl_irq_en_bit");
      add_vec(1, 16'h0014, 32'hFFFFFFFF, 16'h0014, 32'h0,       "unmapped_read");
      add_vec(1, 16'h001C, 32'hFFFFFFFF, A_CTRL,   ctrl_w6,     "unmapped_write_ignored");
      add_vec(1, A_STATUS, 32'hFFFFFFF7, A_STATUS, 32'h2,       "status_ro");
      add_vec(1, A_CTRL,   32'h0,       A_CTRL,   32'h0,        "ctrl_clear");
      add_vec(1, A_CHMASK, 32'h0,       A_CHMASK, 32'h0,        "chmask_clear");
      add_vec(1, A_PERIOD, 32'h0,       A_PERIOD, 32'h0,        "period_clear");

      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      resetn = 1'b0;
      idle(3);
      check("rst_adc_req", 32'(adc_req), 32'd0);
      check("rst_adc_chan", 32'(adc_chan), 32'd0);
      check("rst_prdata", prdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("pready_const", 32'(pready), 32'd1);
      check("pslverr_const", 32'(pslverr), 32'd0);
      resetn = 1'b1;
      idle(2);

      for (int i = 0; i < vecs.size(); i++) begin
         logic [31:0] d;
         if (vecs[i].do_wr) apb_write(vecs[i].waddr, vecs[i].wdata);
         apb_read(vecs[i].raddr, d);
         check(vecs[i].name, d, vecs[i].want);
      end

      // Periodic scan over ch0 and ch2, two scans 100 cycles apart
      adc_auto = 1'b1;
      ack_log.delete();
      apb_write(A_CHMASK, 32'h05);
      apb_write(A_PERIOD, 32'd100);
      apb_write(A_CTRL, 32'h1);
      wait_log(4, 400, "periodic_acks");
      apb_write(A_CTRL, 32'h0);
      if (ack_log.size() >= 4) begin
         for (int i = 0; i < 4; i++) check($sformatf("periodic_chan%0d", i), 32'(ack_log[i].chan), (i % 2) ? 32'd2 : 32'd0);
         check("periodic_interval_ch0", 32'(ack_log[2].rise - ack_log[0].rise), 32'd100);
         check("periodic_interval_ch2", 32'(ack_log[3].rise - ack_log[1].rise), 32'd100);
         idle(10);
         read_check(A_STATUS, 32'h400, "periodic_status");
         for (int i = 0; i < 4; i++) read_check(A_DATA, exp_word(ack_log[i]), $sformatf("periodic_data%0d", i));
         read_check(A_STATUS, 32'h2, "periodic_drained");
      end

      // One-shot over all eight channels
      ack_log.delete();
      apb_write(A_CHMASK, 32'hFF);
      apb_write(A_PERIOD, 32'd10);
      apb_write(A_CTRL, 32'h3);
      wait_log(8, 400, "oneshot_acks");
      idle(5);
      read_check(A_CTRL, 32'h2, "oneshot_en_cleared");
      read_check(A_STATUS, 32'h804, "oneshot_status_full");
      idle(30);
      check("oneshot_no_rescan", ack_log.size(), 8);
      if (ack_log.size() >= 8) begin
         for (int i = 0; i < 8; i++) check($sformatf("oneshot_chan%0d", i), 32'(ack_log[i].chan), 32'(i));
         for (int i = 0; i < 8; i++) read_check(A_DATA, exp_word(ack_log[i]), $sformatf("oneshot_data%0d", i));
      end
      apb_write(A_CTRL, 32'h0);

      // Overflow: two full scans without draining, first eight samples kept
      ack_log.delete();
      apb_write(A_PERIOD, 32'd60);
      apb_write(A_CTRL, 32'h1);
      wait_log(16, 600, "ovf_acks");
      apb_write(A_CTRL, 32'h0);
      idle(10);
      check("irq_gated_by_irq_en", 32'(irq), 32'd0);
      read_check(A_STATUS, 32'h80C, "ovf_status");
      apb_write(A_STATUS, 32'h8);
      read_check(A_STATUS, 32'h804, "ovf_w1c");
      if (ack_log.size() >= 8) begin
         for (int i = 0; i < 8; i++) read_check(A_DATA, exp_word(ack_log[i]), $sformatf("ovf_data%0d", i));
      end
      read_check(A_STATUS, 32'h2, "ovf_drained");

      // EN cleared while a request is outstanding
      adc_auto = 1'b0;
      ack_log.delete();
      apb_write(A_CHMASK, 32'h06);
      apb_write(A_PERIOD, 32'd5);
      apb_write(A_CTRL, 32'h1);
      wait_req(60, "enclr_req_seen");
      check("enclr_first_chan", 32'(adc_chan), 32'd1);
      apb_write(A_CTRL, 32'h0);
      idle(3);
      check("enclr_req_held", 32'(adc_req), 32'd1);
      check("enclr_chan_stable", 32'(adc_chan), 32'd1);
      rises0 = req_rises;
      man_go++;
      wait_log(1, 20, "enclr_ack");
      idle(2);
      check("enclr_req_dropped", 32'(adc_req), 32'd0);
      idle(30);
      check("enclr_no_more_req", 32'(req_rises), 32'(rises0));
      read_check(A_STATUS, 32'h100, "enclr_status_idle");
      if (ack_log.size() >= 1) read_check(A_DATA, exp_word(ack_log[0]), "enclr_data");

      // Empty mask: enabled scans never raise a request
      adc_auto = 1'b1;
      apb_write(A_CHMASK, 32'h0);
      apb_write(A_PERIOD, 32'd3);
      rises0 = req_rises;
      apb_write(A_CTRL, 32'h1);
      idle(60);
      check("mask0_no_req", 32'(req_rises), 32'(rises0));
      apb_write(A_CTRL, 32'h0);
      read_check(A_STATUS, 32'h2, "mask0_fifo_empty");

      // Interrupt follows FIFO occupancy, then reset lands mid-request
      adc_auto = 1'b0;
      ack_log.delete();
      apb_write(A_CHMASK, 32'h08);
      apb_write(A_PERIOD, 32'd4);
      apb_write(A_CTRL, 32'h5);
      idle(2);
      check("irq_while_empty", 32'(irq), 32'd0);
      wait_req(40, "rst_seq_req1");
      man_go++;
      wait_log(1, 20, "rst_seq_ack");
      idle(3);
      check("irq_nonempty", 32'(irq), 32'(IRQ_BUILT));
      rises0 = req_rises;
      idle(1);
      while (req_rises == rises0 && cyc < 90000) @(negedge fclk);
      check("rst_seq_req2", 32'(adc_req), 32'd1);
      check("rst_seq_chan", 32'(adc_chan), 32'd3);
      @(negedge fclk);
      resetn = 1'b0;
      #1;
      check("rst_mid_req_adc_req", 32'(adc_req), 32'd0);
      check("rst_mid_req_adc_chan", 32'(adc_chan), 32'd0);
      check("rst_mid_req_irq", 32'(irq), 32'd0);
      check("rst_mid_req_prdata", prdata, 32'd0);
      @(negedge fclk);
      resetn = 1'b1;
      read_check(A_STATUS, 32'h2, "rst_mid_req_status");
      read_check(A_CTRL, 32'h0, "rst_mid_req_ctrl");
      read_check(A_CHMASK, 32'h0, "rst_mid_req_chmask");
      read_check(A_PERIOD, 32'h0, "rst_mid_req_period");
      idle(10);
      check("rst_no_req_after", 32'(adc_req), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
